// File: rtl/trigger_catcher_mc.sv
// Multi-channel trigger catcher.
// Each channel synchronises an asynchronous pulse input into the clk domain
// and detects the selected edge(s). It emits a one-cycle trigger followed by a
// programmable dead time, and keeps a saturating trigger count plus a sticky
// flag for edges that arrived while the dead time was still running.
module trigger_catcher_mc #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 8,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           edge_mode,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 count_clr,
  input  logic [NCH-1:0]       pulse_in,
  output logic [NCH-1:0]       trigger,
  output logic                 trig_any,
  output logic [NCH-1:0]       lost,
  output logic [NCH*CNT_W-1:0] trig_count
);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  assign trig_any = |trigger;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_q;
    logic [HOLDOFF_W-1:0]   hold_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   trig_q;
    logic                   lost_q;
    logic                   s_n;
    logic                   rise;
    logic                   fall;
    logic                   raw_edge;
    logic                   hold_idle;
    logic                   qual;
    logic                   blocked;

    assign s_n       = sync_q[SYNC_STAGES-1];
    assign rise      = s_n & ~d_q;
    assign fall      = ~s_n & d_q;
    assign hold_idle = (hold_q == '0);
    assign qual      = raw_edge & enable & hold_idle;
    assign blocked   = raw_edge & enable & ~hold_idle;

    // Select which transitions count as an edge for the current mode.
    always_comb begin
      raw_edge = 1'b0;
      case (edge_mode)
        MODE_RISE: raw_edge = rise;
        MODE_FALL: raw_edge = fall;
        MODE_BOTH: raw_edge = rise | fall;
        default:   raw_edge = 1'b0;
      endcase
    end

    // Synchroniser chain plus the previous-sample flop. It keeps running even
    // while disabled, so re-enabling cannot manufacture a stale edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        d_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in[i]};
        d_q    <= s_n;
      end
    end

    // Trigger pulse and dead-time counter; the counter reloads on a trigger
    // and otherwise drains toward zero regardless of enable.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        trig_q <= 1'b0;
        hold_q <= '0;
      end else begin
        trig_q <= qual;
        if (qual)
          hold_q <= holdoff;
        else if (!hold_idle)
          hold_q <= hold_q - 1'b1;
      end
    end

    // Saturating trigger count and sticky lost flag; a clear wins over a
    // coincident update.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        lost_q <= 1'b0;
      end else if (count_clr) begin
        cnt_q  <= '0;
        lost_q <= 1'b0;
      end else begin
        if (qual && (cnt_q != {CNT_W{1'b1}}))
          cnt_q <= cnt_q + 1'b1;
        if (blocked)
          lost_q <= 1'b1;
      end
    end

    assign trigger[i]                  = trig_q;
    assign lost[i]                     = lost_q;
    assign trig_count[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule
